vram_arbiter: RTL and testbench

- Shares one single-port text VRAM (8-bit character codes, 64-column rows) between three requesters:
  - the VGA character fetch path;
  - the CPU load/store port;
  - an internal clear/scroll engine.
- Grants exactly one RAM access per cycle by fixed priority.
- Sequences bulk screen operations (fill screen, scroll up one row) so software no longer loops over video memory.

---
 rtl/vram_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port text VRAM between the VGA character
// fetch path, the CPU load/store port and an internal clear/scroll engine.
// One RAM access per cycle, fixed priority VGA > CPU > engine.
//
// Build option: define VRAM_SCROLL_EN to include the scroll-up engine
// (SCR_RD/SCR_WR/SCR_FILL states and the read-hold register). Without it
// scroll_start is ignored; clear and arbitration are unchanged.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   vga_req/vga_addr      -> vga_rdata/vga_valid (1 cycle after grant)
//   cpu_req/we/addr/wdata -> cpu_ack pulse, cpu_rdata (held between reads)
//   clear_start, scroll_start, fill_char -> busy, done
//   ram_addr/ram_we/ram_wdata -> RAM, ram_rdata <- RAM (1-cycle latency)
module vram_arbiter #(
  parameter int AW   = 11,
  parameter int DW   = 8,
  parameter int COLS = 64,
  parameter int ROWS = 30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic [DW-1:0] vga_rdata,
  output logic          vga_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          clear_start,
  input  logic          scroll_start,
  input  logic [DW-1:0] fill_char,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int          LAST_I   = ROWS*COLS - 1;
  localparam logic [AW:0] LAST_IDX = LAST_I[AW:0];
  localparam logic [AW:0] IDX_ONE  = {{AW{1'b0}}, 1'b1};
`ifdef VRAM_SCROLL_EN
  // Last destination of the row-copy phase; the final row is then filled.
  localparam int            SCR_I    = (ROWS-1)*COLS - 1;
  localparam logic [AW:0]   SCR_LAST = SCR_I[AW:0];
  localparam logic [AW-1:0] COLS_A   = COLS[AW-1:0];
`endif

  typedef enum logic [2:0] {
    IDLE,
    CLR
`ifdef VRAM_SCROLL_EN
    , SCR_RD,
    SCR_WR,
    SCR_FILL
`endif
  } eng_state_e;

  eng_state_e    state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [DW-1:0] fill_q, fill_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          vga_vld_q, vga_vld_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          cpu_rd_q, cpu_rd_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  // High for the first cycle after reset; CPU writes are held off then.
  logic          rst_seen_q;
`ifdef VRAM_SCROLL_EN
  logic          scr_rd_q, scr_rd_d;
  logic [DW-1:0] hold_q, hold_d;
`else
  logic          scroll_unused;
  assign scroll_unused = scroll_start;
`endif

  logic          cpu_elig, vga_gnt, cpu_gnt, eng_gnt;
  logic [AW-1:0] eng_addr;
  logic          eng_we;
  logic [DW-1:0] eng_wdata;

  // One request yields one access: not eligible in its own ack cycle.
  // Writes stall while the engine owns the screen.
  assign cpu_elig = cpu_req && !cpu_ack_q && !(cpu_we && (busy_q || rst_seen_q));

  always_comb begin
    vga_gnt = 1'b0;
    cpu_gnt = 1'b0;
    eng_gnt = 1'b0;
    if (rst) begin
      if (vga_req)               vga_gnt = 1'b1;
      else if (cpu_elig)         cpu_gnt = 1'b1;
      else if (state_q != IDLE)  eng_gnt = 1'b1;
    end
  end

  // Engine sequencing; eng_* describe the access the engine would make if
  // granted this cycle, state only advances on an actual grant.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fill_d    = fill_q;
    done_d    = 1'b0;
    eng_addr  = '0;
    eng_we    = 1'b0;
    eng_wdata = '0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLR;
          idx_d   = '0;
          fill_d  = fill_char;
        end
`ifdef VRAM_SCROLL_EN
        else if (scroll_start) begin
          state_d = SCR_RD;
          idx_d   = '0;
          fill_d  = fill_char;
        end
`endif
      end
      CLR: begin
        eng_addr  = idx_q[AW-1:0];
        eng_we    = 1'b1;
        eng_wdata = fill_q;
        if (eng_gnt) begin
          idx_d = idx_q + IDX_ONE;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
`ifdef VRAM_SCROLL_EN
      SCR_RD: begin
        eng_addr = idx_q[AW-1:0] + COLS_A;
        if (eng_gnt) state_d = SCR_WR;
      end
      SCR_WR: begin
        eng_addr  = idx_q[AW-1:0];
        eng_we    = 1'b1;
        // Back-to-back with the read the data is still on ram_rdata;
        // otherwise it was parked in hold_q.
        eng_wdata = scr_rd_q ? ram_rdata : hold_q;
        if (eng_gnt) begin
          idx_d   = idx_q + IDX_ONE;
          state_d = (idx_q == SCR_LAST) ? SCR_FILL : SCR_RD;
        end
      end
      SCR_FILL: begin
        eng_addr  = idx_q[AW-1:0];
        eng_we    = 1'b1;
        eng_wdata = fill_q;
        if (eng_gnt) begin
          idx_d = idx_q + IDX_ONE;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d    = (state_d != IDLE);
    vga_vld_d = vga_gnt;
    cpu_ack_d = cpu_gnt;
    cpu_rd_d  = cpu_gnt && !cpu_we;
    cpu_rdata_d = (cpu_ack_q && cpu_rd_q) ? ram_rdata : cpu_rdata_q;
`ifdef VRAM_SCROLL_EN
    scr_rd_d = eng_gnt && (state_q == SCR_RD);
    hold_d   = scr_rd_q ? ram_rdata : hold_q;
`endif
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (vga_gnt) begin
      ram_addr = vga_addr;
    end else if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_we ? cpu_wdata : '0;
    end else if (eng_gnt) begin
      ram_addr  = eng_addr;
      ram_we    = eng_we;
      ram_wdata = eng_wdata;
    end
  end

  assign vga_valid = vga_vld_q;
  assign vga_rdata = vga_vld_q ? ram_rdata : '0;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_d;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      fill_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vga_vld_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rd_q    <= 1'b0;
      cpu_rdata_q <= '0;
      rst_seen_q  <= 1'b1;
`ifdef VRAM_SCROLL_EN
      scr_rd_q    <= 1'b0;
      hold_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fill_q      <= fill_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vga_vld_q   <= vga_vld_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rd_q    <= cpu_rd_d;
      cpu_rdata_q <= cpu_rdata_d;
      rst_seen_q  <= 1'b0;
`ifdef VRAM_SCROLL_EN
      scr_rd_q    <= scr_rd_d;
      hold_q      <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: CPU vector table, VGA priority,
// clear, scroll (or scroll-ignored in the default build), CPU write stall
// during busy, and reset in the middle of an operation.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req;
  logic [10:0] vga_addr;
  logic [7:0]  vga_rdata;
  logic        vga_valid;
  logic        cpu_req, cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        clear_start, scroll_start;
  logic [7:0]  fill_char;
  logic        busy, done;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  vram_arbiter dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_valid(vga_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .clear_start(clear_start), .scroll_start(scroll_start), .fill_char(fill_char),
    .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM, 1-cycle read latency.
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboards: expected values queued at drive time, popped on output.
  logic [7:0] cpu_q[$];
  logic [7:0] vga_q[$];
  logic [7:0] last_rd = 8'h00;
  int done_cnt = 0, done_cyc = 0, ack_cyc = 0, wr_cnt = 0, oob = 0;

  always @(negedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (ram_we) begin
      wr_cnt++;
      if (busy && ram_addr >= 11'd1920) oob++;
    end
    if (cpu_ack) begin
      ack_cyc = cyc;
      if (cpu_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL cpu_ack_spurious: got ack expected none (cycle %0d)", cyc);
      end else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    end
    if (vga_valid) begin
      if (vga_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL vga_valid_spurious: got valid expected none (cycle %0d)", cyc);
      end else chk("vga_rdata", vga_rdata, vga_q.pop_front());
    end
  end

  task automatic cpu_xact(input logic we, input logic [10:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input int exp_lat);
    int n;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (we) cpu_q.push_back(last_rd);
    else begin cpu_q.push_back(exp_rd); last_rd = exp_rd; end
    @(negedge clk);
    if (exp_lat == 1) begin
      chk("cpu_gnt_addr", ram_addr, a);
      chk("cpu_gnt_we", ram_we, we);
      chk("cpu_gnt_wdata", ram_wdata, we ? d : 8'h00);
    end
    n = 0;
    while (!cpu_ack && n < 5000) begin @(negedge clk); n++; end
    if (!cpu_ack) begin
      checks++; fails++;
      $display("FAIL cpu_ack_timeout: got no ack expected ack for addr %0h", a);
    end else if (exp_lat >= 0) chk("cpu_ack_latency", n, exp_lat);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;
  vec_t vecs [9];

  int   n, bad, d0, w0, exp_row;
  logic tog, fin;

  initial begin
    vecs[0] = '{1'b1, 11'h005, 8'h41, 8'h00};
    vecs[1] = '{1'b0, 11'h005, 8'h00, 8'h41};
    vecs[2] = '{1'b1, 11'h7FF, 8'hA5, 8'h00};
    vecs[3] = '{1'b0, 11'h7FF, 8'h00, 8'hA5};
    vecs[4] = '{1'b1, 11'h780, 8'h5A, 8'h00};
    vecs[5] = '{1'b0, 11'h780, 8'h00, 8'h5A};
    // readbacks after the 0x20 clear
    vecs[6] = '{1'b0, 11'h000, 8'h00, 8'h20};
    vecs[7] = '{1'b0, 11'h77F, 8'h00, 8'h20};
    vecs[8] = '{1'b0, 11'h780, 8'h00, 8'h5A};

    rst = 1'b0; vga_req = 1'b1; vga_addr = 11'h005; cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 11'h001; cpu_wdata = 8'hEE; clear_start = 1'b0; scroll_start = 1'b0;
    fill_char = 8'h00;

    // Reset: requests present but nothing granted, all outputs 0.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vga_valid", vga_valid, 0);
    chk("rst_vga_rdata", vga_rdata, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b1; vga_req = 1'b0; cpu_req = 1'b0;

    // CPU vectors, no contention: ack one cycle after grant.
    for (int i = 0; i < 6; i++)
      cpu_xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1);

    // VGA holds the RAM while the CPU waits.
    @(posedge clk); #1;
    vga_req = 1'b1; vga_addr = 11'h005;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h7FF;
    cpu_q.push_back(8'hA5); last_rd = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      vga_q.push_back(8'h41);
      @(negedge clk);
      chk("vga_pri_noack", cpu_ack, 0);
      chk("vga_pri_addr", ram_addr, 11'h005);
      chk("vga_pri_valid", vga_valid, (i > 0) ? 1 : 0);
      @(posedge clk); #1;
    end
    vga_req = 1'b0;
    @(negedge clk);
    chk("vga_drop_cpu_addr", ram_addr, 11'h7FF);
    chk("vga_drop_noack", cpu_ack, 0);
    @(negedge clk);
    chk("vga_drop_ack", cpu_ack, 1);
    @(posedge clk); #1; cpu_req = 1'b0;

    // Clear with 0x20, uncontended.
    d0 = done_cnt;
    @(posedge clk); #1; fill_char = 8'h20; clear_start = 1'b1;
    @(posedge clk); #1; clear_start = 1'b0; fill_char = 8'hFF;
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin n++; @(negedge clk); end
    chk("clr_busy_cycles", n, 1920);
    chk("clr_done_level", done, 1);
    repeat (3) @(negedge clk);
    chk("clr_done_once", done_cnt - d0, 1);
    bad = 0;
    for (int a = 0; a < 1920; a++) if (mem[a] !== 8'h20) bad++;
    chk("clr_cells_bad", bad, 0);
    chk("clr_780_untouched", mem[11'h780], 8'h5A);
    for (int i = 6; i < 9; i++)
      cpu_xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1);

`ifdef VRAM_SCROLL_EN
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 64; c++)
        cpu_xact(1'b1, 11'(r*64 + c), 8'(r), 8'h00, 1);

    // Scroll with fill 0x00, VGA stealing every other cycle.
    d0 = done_cnt;
    vga_addr = 11'h7FF;
    @(posedge clk); #1; fill_char = 8'h00; scroll_start = 1'b1;
    @(posedge clk); #1; scroll_start = 1'b0; fill_char = 8'hFF;
    n = 0; tog = 1'b0; fin = 1'b0;
    while (!fin) begin
      tog = !tog; vga_req = tog;
      if (tog) vga_q.push_back(8'hA5);
      @(negedge clk);
      if (!busy || n >= 20000) fin = 1'b1;
      else begin n++; @(posedge clk); #1; end
    end
    chk("scr1_end_busy", busy, 0);
    chk("scr1_done_level", done, 1);
    @(posedge clk); #1; vga_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("scr1_done_once", done_cnt - d0, 1);
    bad = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 64; c++) begin
        exp_row = (r < 29) ? r + 1 : 0;
        if (mem[r*64 + c] !== 8'(exp_row)) bad++;
      end
    chk("scr1_cells_bad", bad, 0);

    // Uncontended scroll with fill 0x77: exact latency.
    d0 = done_cnt;
    @(posedge clk); #1; fill_char = 8'h77; scroll_start = 1'b1;
    @(posedge clk); #1; scroll_start = 1'b0; fill_char = 8'hFF;
    n = 0;
    @(negedge clk);
    while (busy && n < 10000) begin n++; @(negedge clk); end
    chk("scr2_busy_cycles", n, 3776);
    repeat (3) @(negedge clk);
    chk("scr2_done_once", done_cnt - d0, 1);
    bad = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 64; c++) begin
        exp_row = (r < 28) ? r + 2 : ((r == 28) ? 0 : 8'h77);
        if (mem[r*64 + c] !== 8'(exp_row)) bad++;
      end
    chk("scr2_cells_bad", bad, 0);
    chk("scr_780_untouched", mem[11'h780], 8'h5A);
`else
    d0 = done_cnt; w0 = wr_cnt;
    @(posedge clk); #1; fill_char = 8'h00; scroll_start = 1'b1;
    @(posedge clk); #1; scroll_start = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); chk("noscr_busy", busy, 0); end
    chk("noscr_done", done_cnt - d0, 0);
    chk("noscr_writes", wr_cnt - w0, 0);
`endif

    // CPU read granted during busy; CPU write stalled until done.
    @(posedge clk); #1; fill_char = 8'h11; clear_start = 1'b1;
    @(posedge clk); #1; clear_start = 1'b0;
    cpu_xact(1'b0, 11'h7FF, 8'h00, 8'hA5, 1);
    cpu_xact(1'b1, 11'h123, 8'h99, 8'h00, -1);
    chk("stall_ack_after_done", ack_cyc - done_cyc, 1);
    @(negedge clk);
    chk("stall_final_cell", mem[11'h123], 8'h99);

    // Both starts together, reset 100 cycles later.
    d0 = done_cnt;
    @(posedge clk); #1; fill_char = 8'h33; clear_start = 1'b1; scroll_start = 1'b1;
    @(posedge clk); #1; clear_start = 1'b0; scroll_start = 1'b0;
    @(negedge clk);
    chk("both_clr_we", ram_we, 1);
    chk("both_clr_addr", ram_addr, 0);
    chk("both_clr_wdata", ram_wdata, 8'h33);
    repeat (99) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    chk("midrst_no_we", ram_we, 0);
    @(posedge clk); #1; rst = 1'b1;
    w0 = wr_cnt;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("midrst_no_writes", wr_cnt - w0, 0);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_partial_lo", mem[50], 8'h33);
    chk("midrst_partial_hi", mem[1000], 8'h11);

    chk("eng_addr_oob", oob, 0);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("vga_q_drained", vga_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
